// File: rtl/glyph_pixel_map.sv
// glyph_pixel_map: decides whether the current VGA pixel lies on a lit dot of one 5x7 character cell.
module glyph_pixel_map #(
  parameter int GLYPH_SCALE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] VGA_HORZ_COORD,
  input  logic [11:0] VGA_VERT_COORD,
  input  logic [11:0] base_horz,
  input  logic [11:0] base_vert,
  input  logic [5:0]  char_code,
  input  logic        digit_mode,
  input  logic [3:0]  digit,
  output logic [5:0]  digit_code,
  output logic        pixel_on
);
  logic [11:0] dx, dy;
  logic [5:0]  code, idx;
  logic [2:0]  col, row;
  logic [34:0] glyph;
  logic        in_cell, hit;
  // Rows packed top row first; row bit 4 is the leftmost column.
  function automatic logic [34:0] font(input logic [5:0] c);
    case (c)
      6'd0:  font = {5'h0E, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
      6'd1:  font = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h11, 5'h11, 5'h1E};
      6'd2:  font = {5'h0E, 5'h11, 5'h10, 5'h10, 5'h10, 5'h11, 5'h0E};
      6'd3:  font = {5'h1C, 5'h12, 5'h11, 5'h11, 5'h11, 5'h12, 5'h1C};
      6'd4:  font = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h1F};
      6'd5:  font = {5'h1F, 5'h10, 5'h10, 5'h1E, 5'h10, 5'h10, 5'h10};
      6'd6:  font = {5'h0E, 5'h11, 5'h10, 5'h17, 5'h11, 5'h11, 5'h0F};
      6'd7:  font = {5'h11, 5'h11, 5'h11, 5'h1F, 5'h11, 5'h11, 5'h11};
      6'd8:  font = {5'h0E, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      6'd9:  font = {5'h07, 5'h02, 5'h02, 5'h02, 5'h02, 5'h12, 5'h0C};
      6'd10: font = {5'h11, 5'h12, 5'h14, 5'h18, 5'h14, 5'h12, 5'h11};
      6'd11: font = {5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h10, 5'h1F};
      6'd12: font = {5'h11, 5'h1B, 5'h15, 5'h15, 5'h11, 5'h11, 5'h11};
      6'd13: font = {5'h11, 5'h11, 5'h19, 5'h15, 5'h13, 5'h11, 5'h11};
      6'd14: font = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
      6'd15: font = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h10, 5'h10, 5'h10};
      6'd16: font = {5'h0E, 5'h11, 5'h11, 5'h11, 5'h15, 5'h12, 5'h0D};
      6'd17: font = {5'h1E, 5'h11, 5'h11, 5'h1E, 5'h14, 5'h12, 5'h11};
      6'd18: font = {5'h0F, 5'h10, 5'h10, 5'h0E, 5'h01, 5'h01, 5'h1E};
      6'd19: font = {5'h1F, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04, 5'h04};
      6'd20: font = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0E};
      6'd21: font = {5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h0A, 5'h04};
      6'd22: font = {5'h11, 5'h11, 5'h11, 5'h15, 5'h15, 5'h15, 5'h0A};
      6'd23: font = {5'h11, 5'h11, 5'h0A, 5'h04, 5'h0A, 5'h11, 5'h11};
      6'd24: font = {5'h11, 5'h11, 5'h11, 5'h0A, 5'h04, 5'h04, 5'h04};
      6'd25: font = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10, 5'h1F};
      6'd26: font = {5'h0E, 5'h11, 5'h13, 5'h15, 5'h19, 5'h11, 5'h0E};
      6'd27: font = {5'h04, 5'h0C, 5'h04, 5'h04, 5'h04, 5'h04, 5'h0E};
      6'd28: font = {5'h0E, 5'h11, 5'h01, 5'h02, 5'h04, 5'h08, 5'h1F};
      6'd29: font = {5'h1F, 5'h02, 5'h04, 5'h02, 5'h01, 5'h11, 5'h0E};
      6'd30: font = {5'h02, 5'h06, 5'h0A, 5'h12, 5'h1F, 5'h02, 5'h02};
      6'd31: font = {5'h1F, 5'h10, 5'h1E, 5'h01, 5'h01, 5'h11, 5'h0E};
      6'd32: font = {5'h06, 5'h08, 5'h10, 5'h1E, 5'h11, 5'h11, 5'h0E};
      6'd33: font = {5'h1F, 5'h01, 5'h02, 5'h04, 5'h08, 5'h08, 5'h08};
      6'd34: font = {5'h0E, 5'h11, 5'h11, 5'h0E, 5'h11, 5'h11, 5'h0E};
      6'd35: font = {5'h0E, 5'h11, 5'h11, 5'h0F, 5'h01, 5'h02, 5'h0C};
      default: font = 35'd0;
    endcase
  endfunction
  assign digit_code = digit < 4'd10 ? 6'(digit) + 6'd26 : 6'd63;
  always_comb begin
    code    = digit_mode ? digit_code : char_code;
    dx      = VGA_HORZ_COORD - base_horz;
    dy      = VGA_VERT_COORD - base_vert;
    in_cell = dx < 12'(5 * GLYPH_SCALE) && dy < 12'(7 * GLYPH_SCALE);
    col     = 3'(dx / 12'(GLYPH_SCALE));
    row     = 3'(dy / 12'(GLYPH_SCALE));
    glyph   = font(code);
    idx     = in_cell ? 6'((6 - int'(row)) * 5 + 4 - int'(col)) : 6'd0;
    hit     = in_cell && glyph[idx];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pixel_on <= 1'b0;
    else pixel_on <= hit;
endmodule

// File: tb/tb_glyph_pixel_map.sv
// tb_glyph_pixel_map: directed vector table plus hand-written reset, latency and blank-sweep sequences.
module tb_glyph_pixel_map;
  logic        clk = 0, rst_n = 0;
  logic [11:0] vh = 0, vv = 0, bh = 0, bv = 0;
  logic [5:0]  cc = 0;
  logic        dm = 0;
  logic [3:0]  dg = 0;
  logic [5:0]  digit_code;
  logic        pixel_on;
  int          checks = 0, fails = 0;

  glyph_pixel_map dut (
    .clk(clk), .rst_n(rst_n),
    .VGA_HORZ_COORD(vh), .VGA_VERT_COORD(vv),
    .base_horz(bh), .base_vert(bv),
    .char_code(cc), .digit_mode(dm), .digit(dg),
    .digit_code(digit_code), .pixel_on(pixel_on)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [11:0] vh, vv, bh, bv;
    logic [5:0]  cc;
    logic        dm;
    logic [3:0]  dg;
    logic        exp;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [11:0] h, input logic [11:0] v, input logic [11:0] b_h,
                       input logic [11:0] b_v, input logic [5:0] c, input logic m, input logic [3:0] d);
    vh = h; vv = v; bh = b_h; bv = b_v; cc = c; dm = m; dg = d;
  endtask

  vec_t vecs[14];
  logic [3:0]  dig_in[6]  = '{4'd0, 4'd1, 4'd7, 4'd9, 4'd10, 4'd15};
  logic [5:0]  dig_exp[6] = '{6'd26, 6'd27, 6'd33, 6'd35, 6'd63, 6'd63};
  logic [5:0]  blanks[2]  = '{6'd36, 6'd63};

  initial begin
    vecs[0]  = '{"A_r0c0",    100, 50, 100, 50, 0, 0, 0, 0};
    vecs[1]  = '{"A_r0c2",    104, 50, 100, 50, 0, 0, 0, 1};
    vecs[2]  = '{"A_r3c0",    100, 56, 100, 50, 0, 0, 0, 1};
    vecs[3]  = '{"A_r6c4",    109, 63, 100, 50, 0, 0, 0, 1};
    vecs[4]  = '{"A_right",   110, 50, 100, 50, 0, 0, 0, 0};
    vecs[5]  = '{"A_below",   100, 64, 100, 50, 0, 0, 0, 0};
    vecs[6]  = '{"A_left",     99, 50, 100, 50, 0, 0, 0, 0};
    vecs[7]  = '{"I_wrap_in",   2,  0, 4094, 0, 8, 0, 0, 1};
    vecs[8]  = '{"I_wrap_out",  8,  0, 4094, 0, 8, 0, 0, 0};
    vecs[9]  = '{"dig1_r0c2",   4,  0,   0,  0, 0, 1, 1, 1};
    vecs[10] = '{"zero_r3c2",   4,  6,   0,  0, 26, 0, 0, 1};
    vecs[11] = '{"zero_r3c1",   2,  6,   0,  0, 26, 0, 0, 0};
    vecs[12] = '{"Z_r1c0",      0,  2,   0,  0, 25, 0, 0, 0};
    vecs[13] = '{"Z_r1c4",      8,  2,   0,  0, 25, 0, 0, 1};

    // reset: lit stimulus held while reset is low
    drive(104, 50, 100, 50, 0, 0, 0);
    #2 check("reset_low", 8'(pixel_on), 0);
    @(posedge clk); #1 check("reset_held", 8'(pixel_on), 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1 check("reset_release", 8'(pixel_on), 1);
    #2 rst_n = 0;
    #1 check("reset_async", 8'(pixel_on), 0);
    @(negedge clk) rst_n = 1;

    foreach (vecs[i]) begin
      @(negedge clk) drive(vecs[i].vh, vecs[i].vv, vecs[i].bh, vecs[i].bv, vecs[i].cc, vecs[i].dm, vecs[i].dg);
      @(posedge clk); #1 check(vecs[i].name, 8'(pixel_on), 8'(vecs[i].exp));
    end

    for (int i = 0; i < 6; i++) begin
      dg = dig_in[i];
      #1 check($sformatf("digit_code_%0d", dig_in[i]), 8'(digit_code), 8'(dig_exp[i]));
    end

    // latency: alternating lit/unlit pixel, output lags by one edge
    @(negedge clk) drive(100, 50, 100, 50, 0, 0, 0);
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk) drive((i % 2 == 0) ? 12'd104 : 12'd100, 50, 100, 50, 0, 0, 0);
      #1 check($sformatf("lat_hold_%0d", i), 8'(pixel_on), (i % 2 == 0) ? 8'd0 : 8'd1);
      @(posedge clk); #1 check($sformatf("lat_new_%0d", i), 8'(pixel_on), (i % 2 == 0) ? 8'd1 : 8'd0);
    end

    // blank codes and blank digit swept across the whole cell
    for (int b = 0; b < 3; b++) begin
      int lit = 0;
      for (int y = 0; y < 14; y++)
        for (int x = 0; x < 10; x++) begin
          @(negedge clk)
            if (b < 2) drive(12'(200 + x), 12'(30 + y), 200, 30, blanks[b], 0, 0);
            else drive(12'(200 + x), 12'(30 + y), 200, 30, 0, 1, 15);
          @(posedge clk); #1 lit += int'(pixel_on);
        end
      check($sformatf("blank_sweep_%0d", b), 8'(lit), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
